// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped, read-only cache controller.
// Contents:
//   - address and line geometry constants
//   - the controller FSM state type
//   - helpers that split a word address into tag, index and offset, and that
//     pick one word out of a line
package cache_pkg;

    localparam int ADDR_W  = 15;
    localparam int TAG_W   = 3;
    localparam int INDEX_W = 10;
    localparam int OFF_W   = 2;
    localparam int WORD_W  = 32;
    localparam int LINE_W  = 128;
    localparam int LINES   = 1 << INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_MEM_REQ = 2'd2,
        ST_FILL    = 2'd3
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: INDEX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

    // Word k of a line sits at bits [32k+31:32k].
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        return line[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_if.sv
// Bus bundle between the cache controller, the CPU datapath and main memory.
// Signals:
//   cpu_req/cpu_addr          : CPU read request and word address
//   cpu_rdata/cpu_done/cpu_hit: returned word, completion pulse, hit flag
//   busy                      : controller is not idle
//   mem_read/mem_addr         : block-read strobe and block-aligned address
//   mem_rdata                 : 128-bit block returned by memory
//   hit_count/miss_count      : saturating performance counters
// Modports: master = controller side, slave = CPU/memory environment side.
interface cache_if
    import cache_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic                 cpu_req;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [WORD_W-1:0]    cpu_rdata;
    logic                 cpu_done;
    logic                 cpu_hit;
    logic                 busy;
    logic                 mem_read;
    logic [ADDR_W-1:0]    mem_addr;
    logic [LINE_W-1:0]    mem_rdata;
    logic [CNT_W-1:0]     hit_count;
    logic [CNT_W-1:0]     miss_count;

    modport master (
        input  cpu_req, cpu_addr, mem_rdata,
        output cpu_rdata, cpu_done, cpu_hit, busy, mem_read, mem_addr,
               hit_count, miss_count
    );

    modport slave (
        output cpu_req, cpu_addr, mem_rdata,
        input  cpu_rdata, cpu_done, cpu_hit, busy, mem_read, mem_addr,
               hit_count, miss_count
    );

endinterface

// File: rtl/cache_array.sv
// Storage for the 1024-line direct-mapped cache: 128-bit data, 3-bit tag and
// a valid bit per line.
// Ports:
//   clk, rst_n                   : clock, async active-low reset (valid bits only)
//   rd_idx_i                     : combinational read index
//   rd_data_o/rd_tag_o/rd_valid_o: contents of the indexed line
//   we_i, wr_idx_i, wr_tag_i, wr_data_i: single write port, sets valid on write
module cache_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic [LINE_W-1:0]  rd_data_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic               rd_valid_o,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [LINE_W-1:0]  wr_data_i
);

    logic [LINE_W-1:0] data_q  [LINES];
    logic [TAG_W-1:0]  tag_q   [LINES];
    logic [LINES-1:0]  valid_q;

    // Data and tag carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we_i) begin
            data_q[wr_idx_i] <= wr_data_i;
            tag_q[wr_idx_i]  <= wr_tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    assign rd_data_o  = data_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, read-only cache controller. Accepts one word read at a time,
// answers hits from the cache array and fills the line from main memory on a
// miss. Keeps saturating hit/miss counters.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cache_if.master (CPU request/response, memory block read, counters)
// Parameters:
//   CNT_W   : counter width
//   MEM_LAT : cycles mem_read is held before mem_rdata is used (must be >= 1)
module cache_controller
    import cache_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int MEM_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    cache_if.master bus
);

    localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               hit_q, hit_d;
    logic               mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [LINE_W-1:0]  arr_data;
    logic [TAG_W-1:0]   arr_tag;
    logic               arr_valid;
    logic               arr_we;
    logic               lookup_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    cache_array u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (addr_index(addr_q)),
        .rd_data_o  (arr_data),
        .rd_tag_o   (arr_tag),
        .rd_valid_o (arr_valid),
        .we_i       (arr_we),
        .wr_idx_i   (addr_index(addr_q)),
        .wr_tag_i   (addr_tag(addr_q)),
        .wr_data_i  (bus.mem_rdata)
    );

    assign lookup_hit = arr_valid && (arr_tag == addr_tag(addr_q));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        hit_d      = 1'b0;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        arr_we     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (lookup_hit) begin
                    rdata_d   = line_word(arr_data, addr_off(addr_q));
                    done_d    = 1'b1;
                    hit_d     = 1'b1;
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    state_d   = ST_IDLE;
                end else begin
                    mem_read_d = 1'b1;
                    mem_addr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    cnt_d      = LAT_W'(MEM_LAT);
                    state_d    = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                // The strobe drops on the same edge the counter reaches zero.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LAT_W'(1)) begin
                    mem_read_d = 1'b0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                arr_we     = 1'b1;
                rdata_d    = line_word(bus.mem_rdata, addr_off(addr_q));
                done_d     = 1'b1;
                miss_cnt_d = sat_inc(miss_cnt_q);
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_done   = done_q;
    assign bus.cpu_hit    = hit_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, read-only cache controller between the CPU datapath and `main_mem`. It accepts one 15-bit word-address read at a time and looks it up in a 1024-line × 4-word cache. On a hit it returns the word from the line. On a miss it issues a block read to main memory, fills the line, then returns the word. It also keeps saturating hit and miss counters for the performance testbench.

## Interface
- `CNT_W`, 16: width of the hit and miss counters.
- `MEM_LAT`, 1: cycles `mem_read` is held before `mem_rdata` is sampled. It must be at least 1.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cpu_req`, input, 1: read request. Sampled only in IDLE.
- `cpu_addr`, input, 15: word address. Bits are tag[14:12], index[11:2], offset[1:0].
- `cpu_rdata`, output, 32: returned word. Valid while `cpu_done` is 1, and held afterwards.
- `cpu_done`, output, 1: one-cycle completion pulse.
- `cpu_hit`, output, 1: qualifies `cpu_done`. 1 means hit, 0 means miss.
- `busy`, output, 1: high whenever the state is not IDLE.
- `mem_read`, output, 1: block-read strobe to main memory.
- `mem_addr`, output, 15: block-aligned address {tag, index, 2'b00}.
- `mem_rdata`, input, 128: block from memory. Word k is at bits [32k+31:32k].
- `hit_count`, output, CNT_W: saturating count of hits.
- `miss_count`, output, CNT_W: saturating count of misses.

## Operation
- Storage per line:
  - 128-bit data, 3-bit tag, 1 valid bit.
  - Reset clears all 1024 valid bits. Data and tag are not reset.
- FSM states are IDLE, CHECK, MEM_REQ and FILL.
- IDLE:
  - When `cpu_req`=1, latch `cpu_addr` and go to CHECK.
  - When `cpu_req`=0, stay in IDLE.
- CHECK: hit means the line is valid and its stored tag equals the latched tag.
  - On a hit, register the selected word into `cpu_rdata`, pulse `cpu_done`=1 with `cpu_hit`=1, increment `hit_count`, and go to IDLE.
  - On a miss, assert `mem_read`=1, drive `mem_addr`, load the wait counter with MEM_LAT, and go to MEM_REQ.
- MEM_REQ:
  - Hold `mem_read` and `mem_addr` while the wait counter decrements.
  - When it reaches 0, deassert `mem_read` and go to FILL.
- FILL:
  - Write `mem_rdata` into the line, write the tag, and set valid.
  - Set `cpu_rdata` to the offset word of `mem_rdata`, pulse `cpu_done` with `cpu_hit`=0, increment `miss_count`, and go to IDLE.
- A conflicting tag on the same index overwrites the line. There is no write-back because the cache is read-only.
- Counters stop at 2^CNT_W−1 and do not wrap.
- `cpu_req` while `busy`=1 is ignored. The CPU re-asserts after `cpu_done`.
- A request in the same cycle as `cpu_done` is accepted, because the state is already IDLE.

## Timing
- Reset values are all 0: outputs, counters, valid bits, and state = IDLE.
- Asserting `rst_n` mid-miss clears `mem_read` immediately. No line is written.
- Hit latency: a request sampled at edge N gives `cpu_done` high in the cycle after edge N+1.
- Miss latency with MEM_LAT=1:
  - `mem_read` is high in the cycle after edge N+1.
  - Memory updates `mem_rdata` at edge N+2.
  - FILL is the cycle after edge N+2.
  - `cpu_done` is high in the cycle after edge N+3.
  - In general the miss latency is MEM_LAT+2 cycles.
- `mem_rdata` is sampled only in FILL.
- `mem_addr` is stable for the whole time `mem_read` is high.

## Structure
- Package `cache_pkg` holds:
  - ADDR_W=15, TAG_W=3, INDEX_W=10, OFF_W=2, WORD_W=32, LINE_W=128.
  - The FSM state enum.
  - Field-extract functions for tag, index and offset.
- Sub-module `cache_array`:
  - Data, tag and valid storage.
  - Combinational read port indexed by index.
  - One write port.
  - Asynchronous clear of the valid vector.
- The top level holds the FSM, address latch, wait counter and performance counters.

## Test plan
- Reset: all outputs 0, `busy`=0, counters 0. A request for 0x0400 then misses.
- Cold miss, memory model with mem[k]=k:
  - Request 0x0402 gives `mem_read`=1 with `mem_addr`=0x0400.
  - After 3 cycles, `cpu_done`=1, `cpu_hit`=0, `cpu_rdata`=0x402, `miss_count`=1.
- Hit after fill: request 0x0403 gives `cpu_done` after 1 cycle with `cpu_hit`=1, `cpu_rdata`=0x403, `hit_count`=1, and `mem_read` stays 0.
- Conflict:
  - Sequence 0x0400, 0x1400, 0x0400 (same index, tags 0 and 1) gives three misses.
  - `cpu_rdata` values are 0x400, 0x1400, 0x400.
  - `miss_count`=3.
- Reset mid-miss:
  - Drop `rst_n` while in MEM_REQ. `mem_read` falls asynchronously.
  - After release, request the same address: it misses, so the line was not validated.
- Saturation and back-to-back, with CNT_W=4:
  - 20 consecutive hits with `cpu_req` held high give `hit_count` stuck at 15.
  - A new request is accepted in every `cpu_done` cycle.
